tao_ifu: RTL and testbench

Instruction fetch unit for the tao core; sits directly upstream of the decode stage and supplies its `i_inst`/`i_pc` pair.
- Holds the architectural fetch PC and issues one word request at a time to instruction memory over a valid/ready handshake.
- Captures the returned word in a one-entry output buffer and presents it to decode with a valid/ready handshake.
- Accepts PC redirects from the branch/jump logic (`DNPC_EN` path) and squashes any fetch in flight when one arrives.

---
 rtl/tao_ifu.sv | 90 +++++++++
 tb/tb_tao_ifu.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tao_ifu.sv
// tao_ifu: instruction fetch unit with one outstanding memory request and a one-entry decode buffer
module tao_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_rsp_valid,
  output logic        ifu_rsp_ready,
  input  logic [31:0] ifu_rsp_data,
  input  logic        ifu_rsp_err,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, opc_q, opc_d;
  logic        drop_q, drop_d, valid_q, valid_d, err_q, err_d;
  logic        req_hs;
  assign req_hs        = ifu_req_valid & ifu_req_ready;
  assign ifu_req_valid = (state_q == REQ);
  assign ifu_rsp_ready = (state_q == WAIT);
  assign ifu_req_addr  = pc_q;
  assign o_valid       = valid_q;
  assign o_inst        = inst_q;
  assign o_pc          = opc_q;
  assign o_err         = err_q;
  // Fetch sequencing: a redirect always retargets the PC; a response is marked stale if its request predates the redirect
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (req_hs) begin
        state_d = WAIT;
        drop_d  = redirect_en;
      end
      WAIT: if (ifu_rsp_valid) begin
        drop_d = 1'b0;
        if (drop_q | redirect_en) state_d = REQ;
        else begin
          inst_d  = ifu_rsp_data;
          opc_d   = pc_q;
          err_d   = ifu_rsp_err;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = FULL;
        end
      end else if (redirect_en) drop_d = 1'b1;
      FULL: if (redirect_en | i_ready) begin
        valid_d = 1'b0;
        state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_en) pc_d = redirect_pc & 32'hFFFF_FFFC;
  end
  // State, PC and decode buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= 32'd0;
      opc_q   <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_tao_ifu.sv
// tb_tao_ifu: table-driven check of tao_ifu at the default reset PC and at a wrapping reset PC
module tb_tao_ifu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rq_rdy = 1'b0, rs_vld = 1'b0, rs_err = 1'b0, rd_en = 1'b0, dec_rdy = 1'b0;
  logic [31:0] rs_data = 32'd0, rd_pc = 32'd0;
  logic        a_rqv, a_rsr, a_ov, a_err, b_rqv, b_rsr, b_ov, b_err;
  logic [31:0] a_addr, a_inst, a_pc, b_addr, b_inst, b_pc;
  logic        sel = 1'b0;
  int          checks = 0, errors = 0, idx = 0;

  always #5 clk = ~clk;

  tao_ifu dut_a (
    .clk(clk), .rst(rst),
    .ifu_req_valid(a_rqv), .ifu_req_ready(rq_rdy), .ifu_req_addr(a_addr),
    .ifu_rsp_valid(rs_vld), .ifu_rsp_ready(a_rsr), .ifu_rsp_data(rs_data), .ifu_rsp_err(rs_err),
    .redirect_en(rd_en), .redirect_pc(rd_pc),
    .o_valid(a_ov), .i_ready(dec_rdy), .o_inst(a_inst), .o_pc(a_pc), .o_err(a_err)
  );

  tao_ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst),
    .ifu_req_valid(b_rqv), .ifu_req_ready(rq_rdy), .ifu_req_addr(b_addr),
    .ifu_rsp_valid(rs_vld), .ifu_rsp_ready(b_rsr), .ifu_rsp_data(rs_data), .ifu_rsp_err(rs_err),
    .redirect_en(rd_en), .redirect_pc(rd_pc),
    .o_valid(b_ov), .i_ready(dec_rdy), .o_inst(b_inst), .o_pc(b_pc), .o_err(b_err)
  );

  typedef struct {
    logic        rq_rdy, rs_vld;
    logic [31:0] rs_data;
    logic        rs_err, rd_en;
    logic [31:0] rd_pc;
    logic        dec_rdy;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_rsr, e_ov;
    logic [31:0] e_inst, e_pc;
    logic        e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rr, logic rv, logic [31:0] rd, logic re, logic de, logic [31:0] dp, logic di,
                              logic qv, logic [31:0] ad, logic sr, logic ov, logic [31:0] in, logic [31:0] pc, logic er);
    vec_t v;
    v.rq_rdy = rr; v.rs_vld = rv; v.rs_data = rd; v.rs_err = re; v.rd_en = de; v.rd_pc = dp; v.dec_rdy = di;
    v.e_rqv = qv; v.e_addr = ad; v.e_rsr = sr; v.e_ov = ov; v.e_inst = in; v.e_pc = pc; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec %0d %s got %h expected %h", idx, n, act, exp);
    end
  endtask

  task automatic chk_out(input logic qv, input logic [31:0] ad, input logic sr, input logic ov,
                         input logic [31:0] in, input logic [31:0] pc, input logic er);
    chk("req_valid", {31'd0, sel ? b_rqv : a_rqv}, {31'd0, qv});
    chk("req_addr",  sel ? b_addr : a_addr, ad);
    chk("rsp_ready", {31'd0, sel ? b_rsr : a_rsr}, {31'd0, sr});
    chk("o_valid",   {31'd0, sel ? b_ov : a_ov}, {31'd0, ov});
    chk("o_inst",    sel ? b_inst : a_inst, in);
    chk("o_pc",      sel ? b_pc : a_pc, pc);
    chk("o_err",     {31'd0, sel ? b_err : a_err}, {31'd0, er});
  endtask

  task automatic drive(input vec_t v);
    rq_rdy = v.rq_rdy; rs_vld = v.rs_vld; rs_data = v.rs_data; rs_err = v.rs_err;
    rd_en = v.rd_en; rd_pc = v.rd_pc; dec_rdy = v.dec_rdy;
  endtask

  task automatic run_table();
    for (int i = 0; i < tv.size(); i++) begin
      idx = i;
      drive(tv[i]);
      #1;
      chk_out(tv[i].e_rqv, tv[i].e_addr, tv[i].e_rsr, tv[i].e_ov, tv[i].e_inst, tv[i].e_pc, tv[i].e_err);
      @(negedge clk);
    end
  endtask

  localparam logic [31:0] P0 = 32'h8000_0000;

  initial begin
    // Reset values while rst is held low
    @(negedge clk);
    idx = -1;
    chk_out(1'b0, P0, 1'b0, 1'b0, 32'd0, P0, 1'b0);
    @(negedge clk);
    // rq rv data err rd rdpc dec | rqv addr rsr ov inst pc err
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,0, 0,P0,0,0,32'h0,P0,0));
    tv.push_back(mk(1,0,32'h0,0,0,32'h0,0, 1,P0,0,0,32'h0,P0,0));
    tv.push_back(mk(0,1,32'h00100093,0,0,32'h0,0, 0,P0,1,0,32'h0,P0,0));
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,1, 0,32'h80000004,0,1,32'h00100093,P0,0));
    tv.push_back(mk(1,0,32'h0,0,0,32'h0,0, 1,32'h80000004,0,0,32'h00100093,P0,0));
    tv.push_back(mk(0,1,32'h00200113,0,0,32'h0,0, 0,32'h80000004,1,0,32'h00100093,P0,0));
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,1, 0,32'h80000008,0,1,32'h00200113,32'h80000004,0));
    tv.push_back(mk(0,1,32'h11111111,0,0,32'h0,0, 1,32'h80000008,0,0,32'h00200113,32'h80000004,0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0,0,32'h0,0,0,32'h0,0, 1,32'h80000008,0,0,32'h00200113,32'h80000004,0));
    tv.push_back(mk(1,0,32'h0,0,0,32'h0,0, 1,32'h80000008,0,0,32'h00200113,32'h80000004,0));
    tv.push_back(mk(0,1,32'h00300193,0,0,32'h0,0, 0,32'h80000008,1,0,32'h00200113,32'h80000004,0));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0,0,32'h0,0,0,32'h0,0, 0,32'h8000000C,0,1,32'h00300193,32'h80000008,0));
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,1, 0,32'h8000000C,0,1,32'h00300193,32'h80000008,0));
    tv.push_back(mk(1,0,32'h0,0,0,32'h0,0, 1,32'h8000000C,0,0,32'h00300193,32'h80000008,0));
    tv.push_back(mk(0,0,32'h0,0,1,32'h80000103,0, 0,32'h8000000C,1,0,32'h00300193,32'h80000008,0));
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,0, 0,32'h80000100,1,0,32'h00300193,32'h80000008,0));
    tv.push_back(mk(0,1,32'hDEADBEEF,0,0,32'h0,0, 0,32'h80000100,1,0,32'h00300193,32'h80000008,0));
    tv.push_back(mk(1,0,32'h0,0,0,32'h0,0, 1,32'h80000100,0,0,32'h00300193,32'h80000008,0));
    tv.push_back(mk(0,1,32'h00400213,0,0,32'h0,0, 0,32'h80000100,1,0,32'h00300193,32'h80000008,0));
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,1, 0,32'h80000104,0,1,32'h00400213,32'h80000100,0));
    tv.push_back(mk(1,0,32'h0,0,1,32'h80000200,0, 1,32'h80000104,0,0,32'h00400213,32'h80000100,0));
    tv.push_back(mk(0,1,32'hBADBAD00,0,0,32'h0,0, 0,32'h80000200,1,0,32'h00400213,32'h80000100,0));
    tv.push_back(mk(1,0,32'h0,0,0,32'h0,0, 1,32'h80000200,0,0,32'h00400213,32'h80000100,0));
    tv.push_back(mk(0,1,32'h00500293,0,0,32'h0,0, 0,32'h80000200,1,0,32'h00400213,32'h80000100,0));
    tv.push_back(mk(0,0,32'h0,0,1,32'h80000300,1, 0,32'h80000204,0,1,32'h00500293,32'h80000200,0));
    tv.push_back(mk(1,0,32'h0,0,0,32'h0,0, 1,32'h80000300,0,0,32'h00500293,32'h80000200,0));
    tv.push_back(mk(0,1,32'h00000073,1,0,32'h0,0, 0,32'h80000300,1,0,32'h00500293,32'h80000200,0));
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,1, 0,32'h80000304,0,1,32'h00000073,32'h80000300,1));
    tv.push_back(mk(0,0,32'h0,0,1,32'h80000400,0, 1,32'h80000304,0,0,32'h00000073,32'h80000300,1));
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,0, 1,32'h80000400,0,0,32'h00000073,32'h80000300,1));
    tv.push_back(mk(1,0,32'h0,0,0,32'h0,0, 1,32'h80000400,0,0,32'h00000073,32'h80000300,1));
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,0, 0,32'h80000400,1,0,32'h00000073,32'h80000300,1));
    rst = 1'b1;
    run_table();
    // Asynchronous reset in WAIT while a response is pending at memory
    idx = 100;
    rs_vld = 1'b1; rs_data = 32'hCAFE0000; rq_rdy = 1'b0; rd_en = 1'b0; dec_rdy = 1'b0;
    #2 rst = 1'b0;
    #1 chk_out(1'b0, P0, 1'b0, 1'b0, 32'd0, P0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idx = 101;
    #1 chk_out(1'b0, P0, 1'b0, 1'b0, 32'd0, P0, 1'b0);
    @(negedge clk);
    idx = 102;
    #1 chk_out(1'b1, P0, 1'b0, 1'b0, 32'd0, P0, 1'b0);
    @(negedge clk);
    idx = 103;
    #1 chk_out(1'b1, P0, 1'b0, 1'b0, 32'd0, P0, 1'b0);
    // Wrapping reset PC on the second instance
    rs_vld = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    sel = 1'b1;
    tv.delete();
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,0, 0,32'hFFFFFFFC,0,0,32'h0,32'hFFFFFFFC,0));
    tv.push_back(mk(1,0,32'h0,0,0,32'h0,0, 1,32'hFFFFFFFC,0,0,32'h0,32'hFFFFFFFC,0));
    tv.push_back(mk(0,1,32'h00100093,0,0,32'h0,0, 0,32'hFFFFFFFC,1,0,32'h0,32'hFFFFFFFC,0));
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,1, 0,32'h00000000,0,1,32'h00100093,32'hFFFFFFFC,0));
    tv.push_back(mk(1,0,32'h0,0,0,32'h0,0, 1,32'h00000000,0,0,32'h00100093,32'hFFFFFFFC,0));
    tv.push_back(mk(0,1,32'h00000013,1,0,32'h0,0, 0,32'h00000000,1,0,32'h00100093,32'hFFFFFFFC,0));
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,0, 0,32'h00000004,0,1,32'h00000013,32'h00000000,1));
    tv.push_back(mk(0,0,32'h0,0,0,32'h0,0, 0,32'h00000004,0,1,32'h00000013,32'h00000000,1));
    rst = 1'b1;
    run_table();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
